hazard_ctrl: RTL

Unified, parametrised hazard unit for the in-order MIPS pipeline. It replaces the separate forwarding and stall logic with one block covering:
- Forwarding over NSTAGE producer stages.
- Load/CP0-use and branch-operand interlocks.
- A sequential HI/LO busy tracker for multi-cycle mul/div.

It sits beside the ID/EX control path and drives the PC, IF/ID, ID/EX-bubble and operand-select muxes.

---
 rtl/hazard_pkg.sv | 32 +++
 rtl/hazard_ctrl_md_busy_tracker.sv | 45 ++++
 rtl/hazard_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared constants and the forwarding-priority helper for the hazard unit.
// Stage arrays are padded to MAX_STAGES x MAX_AW so one helper serves every parameterisation.
package hazard_pkg;

    localparam int unsigned SEL_RF          = 0;
    localparam int          MUL_LAT_DEFAULT = 2;
    localparam int          DIV_LAT_DEFAULT = 32;
    localparam int          MAX_STAGES      = 8;
    localparam int          MAX_AW          = 8;

    typedef logic [MAX_AW-1:0]                   reg_idx_t;
    typedef logic [MAX_STAGES-1:0][MAX_AW-1:0]   stage_rd_t;

    // Stage 0 is never a forwarding source; the lowest eligible match is the youngest producer.
    function automatic int unsigned lowest_match(
        input reg_idx_t                src,
        input logic [MAX_STAGES-1:0]   eligible,
        input stage_rd_t               rd
    );
        int unsigned sel;
        sel = SEL_RF;
        if (src != '0) begin
            for (int unsigned k = MAX_STAGES - 1; k >= 1; k--) begin
                if (eligible[k] && rd[k] == src) begin
                    sel = k;
                end
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_tracker.sv
// HI/LO busy tracker: counts down the mul/div latency and pulses md_cancel when a
// flush kills an in-flight or just-issued mul/div.
module md_busy_tracker
    import hazard_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEFAULT,
    parameter int DIV_LAT = DIV_LAT_DEFAULT
) (
    input  logic clk,
    input  logic resetn,
    input  logic flush,
    input  logic ex_md_start,
    input  logic ex_md_is_div,
    output logic md_busy,
    output logic md_cancel
);

    localparam int CW = $clog2(DIV_LAT + 1);

    logic [CW-1:0] count;

    // Flush beats a same-cycle start because the issuing instruction is being killed.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (ex_md_start) begin
            count <= ex_md_is_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
        end else if (count != '0) begin
            count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            md_cancel <= 1'b0;
        end else begin
            md_cancel <= flush && ((count != '0) || ex_md_start);
        end
    end

    assign md_busy = (count != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Unified hazard unit: operand forwarding selects, load/branch/HI-LO interlocks and front-end enables.
// Optional per-cause stall counters are built when HAZARD_PERF_EN is defined; NSTAGE <= 8, AW <= 8.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int AW      = 5,
    parameter int NSTAGE  = 3,
    parameter int SELW    = $clog2(NSTAGE),
    parameter int MUL_LAT = MUL_LAT_DEFAULT,
    parameter int DIV_LAT = DIV_LAT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [AW-1:0]        id_rs,
    input  logic [AW-1:0]        id_rt,
    input  logic                 id_use_rs,
    input  logic                 id_use_rt,
    input  logic                 id_is_branch,
    input  logic                 id_rd_hilo,
    input  logic                 id_is_md,
    input  logic [AW-1:0]        ex_rs,
    input  logic [AW-1:0]        ex_rt,
    input  logic                 ex_md_start,
    input  logic                 ex_md_is_div,
    input  logic [NSTAGE-1:0]    stg_wr,
    input  logic [NSTAGE*AW-1:0] stg_rd,
    input  logic [NSTAGE-1:0]    stg_late,
    input  logic                 flush,
    output logic [SELW-1:0]      ex_rs_sel,
    output logic [SELW-1:0]      ex_rt_sel,
    output logic [SELW-1:0]      id_rs_sel,
    output logic [SELW-1:0]      id_rt_sel,
    output logic                 pc_wr,
    output logic                 if_id_wr,
    output logic                 inst_sram_en,
    output logic                 id_ex_bubble,
    output logic                 md_busy,
    output logic                 md_cancel
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]          perf_stall_ld,
    output logic [31:0]          perf_stall_br,
    output logic [31:0]          perf_stall_md
`endif
);

    stage_rd_t             rd_ext;
    logic [MAX_STAGES-1:0] ex_elig;
    logic [MAX_STAGES-1:0] id_elig;
    logic [NSTAGE-1:0]     hit_id;
    logic                  stall_a;
    logic                  stall_b;
    logic                  stall_c;
    logic                  stall_d;
    logic                  stall;

    // hit_id[k]: stage k writes a nonzero register that the ID instruction really reads.
    always_comb begin
        rd_ext  = '0;
        ex_elig = '0;
        id_elig = '0;
        hit_id  = '0;
        for (int k = 0; k < NSTAGE; k++) begin
            rd_ext[k]  = MAX_AW'(stg_rd[k*AW +: AW]);
            ex_elig[k] = stg_wr[k];
            id_elig[k] = stg_wr[k] & ~stg_late[k];
            hit_id[k]  = stg_wr[k] && (stg_rd[k*AW +: AW] != '0) &&
                         ((id_use_rs && stg_rd[k*AW +: AW] == id_rs) ||
                          (id_use_rt && stg_rd[k*AW +: AW] == id_rt));
        end
    end

    assign ex_rs_sel = SELW'(lowest_match(MAX_AW'(ex_rs), ex_elig, rd_ext));
    assign ex_rt_sel = SELW'(lowest_match(MAX_AW'(ex_rt), ex_elig, rd_ext));
    assign id_rs_sel = SELW'(lowest_match(MAX_AW'(id_rs), id_elig, rd_ext));
    assign id_rt_sel = SELW'(lowest_match(MAX_AW'(id_rt), id_elig, rd_ext));

    always_comb begin
        stall_a = stg_late[0] & hit_id[0];
        stall_b = id_is_branch & hit_id[0];
        stall_c = 1'b0;
        for (int k = 1; k < NSTAGE; k++) begin
            stall_c = stall_c | (id_is_branch & stg_late[k] & hit_id[k]);
        end
        stall_d = md_busy & (id_rd_hilo | id_is_md);
        stall   = stall_a | stall_b | stall_c | stall_d;
    end

    // Reset holds the front end; a flush must always let the redirect through.
    always_comb begin
        pc_wr        = 1'b1;
        if_id_wr     = 1'b1;
        inst_sram_en = 1'b1;
        id_ex_bubble = 1'b0;
        if (!resetn) begin
            pc_wr        = 1'b0;
            if_id_wr     = 1'b0;
            inst_sram_en = 1'b0;
            id_ex_bubble = 1'b1;
        end else if (flush) begin
            pc_wr        = 1'b1;
            if_id_wr     = 1'b1;
            inst_sram_en = 1'b1;
            id_ex_bubble = 1'b0;
        end else if (stall) begin
            pc_wr        = 1'b0;
            if_id_wr     = 1'b0;
            inst_sram_en = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

    md_busy_tracker #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_md_busy_tracker (
        .clk          (clk),
        .resetn       (resetn),
        .flush        (flush),
        .ex_md_start  (ex_md_start),
        .ex_md_is_div (ex_md_is_div),
        .md_busy      (md_busy),
        .md_cancel    (md_cancel)
    );

`ifdef HAZARD_PERF_EN
    // A branch stall is only billed to the branch counter when no load-type cause is present.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            perf_stall_ld <= '0;
            perf_stall_br <= '0;
            perf_stall_md <= '0;
        end else if (!flush) begin
            if (stall_a || stall_c) begin
                perf_stall_ld <= perf_stall_ld + 32'd1;
            end
            if (stall_b && !stall_a && !stall_c) begin
                perf_stall_br <= perf_stall_br + 32'd1;
            end
            if (stall_d) begin
                perf_stall_md <= perf_stall_md + 32'd1;
            end
        end
    end
`endif

endmodule
